histogram_equalizer_lut: RTL and testbench

//  Downstream consumer of histogram_calculator. On each histogram-ready pulse, sweeps the 256-bin

---
 rtl/histogram_equalizer_lut.sv | 205 ++++++++++++++++++++
 tb/tb_histogram_equalizer_lut.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_equalizer_lut.sv
// histogram_equalizer_lut
//   Builds an 8-bit histogram-equalization LUT from a 256-bin histogram and
//   remaps a pixel stream through it. Each hist_ready pulse starts a sweep:
//   the bins are read one per cycle, the CDF is accumulated, and
//   LUT[k] = min(255, (cdf_k*255) >> SHIFT) is written into the shadow bank.
//   The finished shadow bank becomes the active one at the next end_of_frame,
//   so a frame is never remapped through a partly built table.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   hist_ready          1-cycle pulse: histogram complete, start a sweep
//   hist_addr/hist_data histogram read port (data valid 1 cycle after addr)
//   in_pixel/in_valid   input pixel stream, end_of_frame marks a frame boundary
//   out_pixel/out_valid remapped pixels, 2-cycle latency, out_end_of_frame aligned
//   lut_busy            sweep in progress
//   lut_done            1-cycle pulse: shadow LUT complete
module histogram_equalizer_lut #(
  parameter int CNT_W = 16,
  parameter int SHIFT = 16,
  parameter int CDF_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hist_ready,
  output logic [7:0]       hist_addr,
  input  logic [CNT_W-1:0] hist_data,
  input  logic [7:0]       in_pixel,
  input  logic             in_valid,
  input  logic             end_of_frame,
  output logic [7:0]       out_pixel,
  output logic             out_valid,
  output logic             out_end_of_frame,
  output logic             lut_busy,
  output logic             lut_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic               drain_cnt;
  logic               sweep_start;

  // Sweep pipeline: address issue -> data return -> CDF register -> LUT write
  logic               rd_valid;
  logic [7:0]         rd_addr;
  logic               cdf_valid;
  logic [7:0]         wr_addr;
  logic [CDF_W-1:0]   cdf;
  logic [CDF_W+7:0]   prod;
  logic [CDF_W+7:0]   scaled;
  logic [7:0]         lut_val;

  // Bank control
  logic               active_bank;
  logic               swap_pending;
  logic               lut_loaded;
  logic               do_swap;

  // Two banks of 256 entries, indexed {bank, addr}
  logic [7:0]         lut_mem [0:511];

  // Pixel pipeline stage 1
  logic [7:0]         pix1;
  logic               valid1;
  logic               eof1;
  logic               bank1;
  logic               loaded1;
  logic [7:0]         lut_rd;

  assign sweep_start = hist_ready && (state == S_IDLE);
  assign do_swap     = end_of_frame && swap_pending;

  // Sweep FSM; all status outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hist_addr <= '0;
      drain_cnt <= 1'b0;
      lut_busy  <= 1'b0;
      lut_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hist_ready) begin
            state     <= S_READ;
            hist_addr <= '0;
            lut_busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (hist_addr == 8'hFF) begin
            state     <= S_DRAIN;
            hist_addr <= '0;
            drain_cnt <= 1'b0;
          end else begin
            hist_addr <= hist_addr + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state    <= S_DONE;
            lut_done <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          lut_done <= 1'b0;
          lut_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // CDF accumulation: bin data is valid the cycle after its address is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      cdf_valid <= 1'b0;
      wr_addr   <= '0;
      cdf       <= '0;
    end else begin
      rd_valid  <= (state == S_READ);
      rd_addr   <= hist_addr;
      cdf_valid <= rd_valid;
      wr_addr   <= rd_addr;
      if (sweep_start)
        cdf <= '0;
      else if (rd_valid)
        cdf <= cdf + CDF_W'(hist_data);
    end
  end

  // Scale at full width before the shift, then saturate to 8 bits
  always_comb begin
    prod    = {8'd0, cdf} * (CDF_W+8)'(255);
    scaled  = prod >> SHIFT;
    lut_val = (|scaled[CDF_W+7:8]) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk) begin
    if (cdf_valid)
      lut_mem[{~active_bank, wr_addr}] <= lut_val;
  end

  // swap_pending is cleared at sweep start, so an abandoned or superseded
  // sweep can never be swapped in; lut_done and sweep_start never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_pending <= 1'b0;
      active_bank  <= 1'b0;
      lut_loaded   <= 1'b0;
    end else begin
      if (sweep_start)
        swap_pending <= 1'b0;
      else if (lut_done)
        swap_pending <= 1'b1;
      else if (do_swap)
        swap_pending <= 1'b0;
      if (do_swap) begin
        active_bank <= ~active_bank;
        lut_loaded  <= 1'b1;
      end
    end
  end

  assign lut_rd = lut_mem[{bank1, pix1}];

  // Bank select captured with the pixel, so a pixel sampled on the swap
  // edge still uses the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1             <= '0;
      valid1           <= 1'b0;
      eof1             <= 1'b0;
      bank1            <= 1'b0;
      loaded1          <= 1'b0;
      out_pixel        <= '0;
      out_valid        <= 1'b0;
      out_end_of_frame <= 1'b0;
    end else begin
      pix1             <= in_pixel;
      valid1           <= in_valid;
      eof1             <= end_of_frame;
      bank1            <= active_bank;
      loaded1          <= lut_loaded;
      out_valid        <= valid1;
      out_end_of_frame <= eof1;
      if (!valid1)
        out_pixel <= '0;
      else if (loaded1)
        out_pixel <= lut_rd;
      else
        out_pixel <= pix1;
    end
  end

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// tb_histogram_equalizer_lut
//   Scoreboard bench: each driven pixel/end_of_frame pushes its expected
//   output (from a bench-side LUT and bank model) and the monitor pops and
//   compares whenever the DUT presents output.
module tb_histogram_equalizer_lut;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             hist_ready;
  logic [7:0]       hist_addr;
  logic [CNT_W-1:0] hist_data;
  logic [7:0]       in_pixel;
  logic             in_valid;
  logic             end_of_frame;
  logic [7:0]       out_pixel;
  logic             out_valid;
  logic             out_end_of_frame;
  logic             lut_busy;
  logic             lut_done;

  histogram_equalizer_lut #(
    .CNT_W(CNT_W),
    .SHIFT(16),
    .CDF_W(24)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hist_ready      (hist_ready),
    .hist_addr       (hist_addr),
    .hist_data       (hist_data),
    .in_pixel        (in_pixel),
    .in_valid        (in_valid),
    .end_of_frame    (end_of_frame),
    .out_pixel       (out_pixel),
    .out_valid       (out_valid),
    .out_end_of_frame(out_end_of_frame),
    .lut_busy        (lut_busy),
    .lut_done        (lut_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered histogram RAM
  logic [CNT_W-1:0] hist_mem [256];
  always @(posedge clk) hist_data <= hist_mem[hist_addr];

  typedef struct {
    logic       v;
    logic       e;
    logic [7:0] p;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  int checks   = 0;
  int failures = 0;

  // Bench model of LUT banks and swap state
  logic [7:0] m_lut [2][256];
  bit         m_active  = 1'b0;
  bit         m_loaded  = 1'b0;
  bit         m_pending = 1'b0;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic build_model(input int bank);
    longint c = 0;
    longint v;
    for (int i = 0; i < 256; i++) begin
      c += longint'(hist_mem[i]);
      v = (c * 255) >>> 16;
      m_lut[bank][i] = (v > 255) ? 8'd255 : v[7:0];
    end
  endtask

  // Drive one cycle of inputs, push expectation, then advance to the next cycle
  task automatic step(input logic v, input logic [7:0] p, input logic e, input logic hr);
    exp_t x;
    in_valid     = v;
    in_pixel     = p;
    end_of_frame = e;
    hist_ready   = hr;
    if (v || e) begin
      x.v   = v;
      x.e   = e;
      x.p   = !v ? 8'd0 : (m_loaded ? m_lut[m_active][p] : p);
      x.due = int'(cyc) + 2;
      sb.push_back(x);
    end
    if (e && m_pending) begin
      m_active  = !m_active;
      m_loaded  = 1'b1;
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic stream_rand(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  // Full sweep; optional end_of_frame in the lut_done cycle and an extra
  // hist_ready at sweep cycle extra_hr (0 = none)
  task automatic sweep(input bit eof_at_done, input int extra_hr, input string tag);
    int done_n = -1;
    int extra_done = 0;
    m_pending = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 400; n++) begin
      if (n == 1) begin
        check({tag, "_busy_c1"}, lut_busy, 1);
        check({tag, "_addr_c1"}, hist_addr, 0);
      end
      if (n == 256) check({tag, "_addr_c256"}, hist_addr, 255);
      if (n == 257) check({tag, "_addr_c257"}, hist_addr, 0);
      if (lut_done) begin
        done_n = n;
        break;
      end
      step(1'b0, 8'd0, 1'b0, logic'(n == extra_hr));
    end
    check({tag, "_done_cycle"}, done_n, 259);
    check({tag, "_busy_at_done"}, lut_busy, 1);
    step(1'b0, 8'd0, logic'(eof_at_done), 1'b0);
    build_model(int'(!m_active));
    m_pending = 1'b1;
    check({tag, "_busy_after"}, lut_busy, 0);
    for (int i = 0; i < 6; i++) begin
      if (lut_done) extra_done++;
      step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    check({tag, "_extra_done"}, extra_done, 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || out_end_of_frame) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          mon_x = sb.pop_front();
          check("out", {out_valid, out_end_of_frame, out_pixel}, {mon_x.v, mon_x.e, mon_x.p});
          check("latency", cyc, mon_x.due);
        end
      end else begin
        check("idle_zero", out_pixel, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst = 1'b1;
    hist_ready = 1'b0;
    in_pixel = '0;
    in_valid = 1'b0;
    end_of_frame = 1'b0;
    for (int i = 0; i < 256; i++) hist_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_eof", out_end_of_frame, 0);
    check("rst_busy", lut_busy, 0);
    check("rst_done", lut_done, 0);
    check("rst_addr", hist_addr, 0);
    rst = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0);

    // Bypass before any swap, with end_of_frame alignment
    stream_rand(8);
    step(1'b1, 8'd200, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    stream_rand(5);
    drain("bypass");

    // Uniform histogram
    for (int i = 0; i < 256; i++) hist_mem[i] = 16'd256;
    sweep(1'b0, 0, "uniform");
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd127, 1'b0, 1'b0);
    step(1'b1, 8'd255, 1'b0, 1'b0);
    stream_rand(10);
    drain("uniform");

    // Saturating histogram; eof coincident with lut_done must not swap
    for (int i = 0; i < 256; i++) hist_mem[i] = '0;
    hist_mem[0] = 16'hFFFF;
    hist_mem[1] = 16'hFFFF;
    sweep(1'b1, 0, "sat");
    step(1'b1, 8'd127, 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd128, 1'b0, 1'b0);
    step(1'b1, 8'd255, 1'b0, 1'b0);
    drain("sat");

    // Extra hist_ready during READ, then rebuild while swap pending
    for (int i = 0; i < 256; i++) hist_mem[i] = 16'($urandom_range(0, 511));
    sweep(1'b0, 50, "rebuild_a");
    for (int i = 0; i < 256; i++) hist_mem[i] = 16'($urandom_range(0, 511));
    sweep(1'b0, 0, "rebuild_b");
    step(1'b0, 8'd0, 1'b1, 1'b0);
    stream_rand(16);
    drain("rebuild");

    // Reset in the middle of a sweep
    step(1'b0, 8'd0, 1'b0, 1'b1);
    for (int n = 1; n < 100; n++) step(1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_busy", lut_busy, 0);
    check("midrst_addr", hist_addr, 0);
    check("midrst_done", lut_done, 0);
    check("midrst_out_valid", out_valid, 0);
    m_active  = 1'b0;
    m_loaded  = 1'b0;
    m_pending = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      if (lut_done) dones++;
      step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    check("midrst_no_done", dones, 0);
    check("midrst_busy_after", lut_busy, 0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    stream_rand(12);
    drain("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
